netwalk_decoder: RTL and testbench



---
 rtl/netwalk_pkg.sv | 18 +
 rtl/netwalk_onehot.sv | 20 ++
 rtl/netwalk_decoder.sv | 126 ++++++++++++
 tb/tb_netwalk_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/netwalk_pkg.sv
// netwalk_pkg: shared constants and types for the netwalk cell-select path.
//   NETWALK_IDX_W    - width of a binary cell index
//   NETWALK_CELLS    - number of cells in the tile array
//   NETWALK_LAST_IDX - index of the final cell (end of a sweep)
//   dec_state_e      - decoder FSM state encoding
package netwalk_pkg;

   localparam int NETWALK_IDX_W = 6;
   localparam int NETWALK_CELLS = 1 << NETWALK_IDX_W;

   localparam logic [NETWALK_IDX_W-1:0] NETWALK_LAST_IDX = 6'h3F;

   typedef enum logic {
      DEC_IDLE  = 1'b0,
      DEC_SWEEP = 1'b1
   } dec_state_e;

endpackage

// File: rtl/netwalk_onehot.sv
// netwalk_onehot: purely combinational binary index to one-hot conversion.
// Shared by the decoder request and sweep paths; reusable by the tile array.
//   idx    - binary cell index
//   onehot - bit idx set, all other bits clear
module netwalk_onehot
   import netwalk_pkg::*;
#(
   parameter  int IDX_W = NETWALK_IDX_W,
   localparam int CELLS = 1 << IDX_W
) (
   input  logic [IDX_W-1:0] idx,
   output logic [CELLS-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/netwalk_decoder.sv
// netwalk_decoder: registered binary-to-one-hot decoder with a one-entry
// valid/ready output register and a built-in 0..63 sweep mode.
//   clk          - system clock, all state on the rising edge
//   reset        - asynchronous active-low reset
//   in_valid     - decoder_in holds a request
//   in_ready     - a request is accepted this cycle
//   decoder_in   - binary index to decode
//   sweep_start  - request a full sweep over every index (level-sensitive)
//   out_valid    - decoder_out/out_index hold a beat
//   out_ready    - consumer takes the beat this cycle
//   decoder_out  - one-hot select, zero when no beat is held
//   out_index    - binary index of the current beat
//   out_last     - current beat is the final sweep beat
//   busy         - a sweep is in progress
module netwalk_decoder
   import netwalk_pkg::*;
#(
   parameter  int DECODER_IN_WIDTH  = NETWALK_IDX_W,
   localparam int DECODER_OUT_WIDTH = 1 << DECODER_IN_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DECODER_IN_WIDTH-1:0]  decoder_in,
   input  logic                         sweep_start,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DECODER_OUT_WIDTH-1:0] decoder_out,
   output logic [DECODER_IN_WIDTH-1:0]  out_index,
   output logic                         out_last,
   output logic                         busy
);

   dec_state_e                   state_q, state_d;
   logic                         out_valid_q, valid_d;
   logic                         out_last_q, last_d;
   logic [DECODER_IN_WIDTH-1:0]  out_index_q, index_d, index_inc;
   logic [DECODER_OUT_WIDTH-1:0] decoder_out_q, onehot_d;

   logic load_ok;
   logic sweep_go;
   logic req_take;
   logic beat_take;

   // The one-hot is computed from the next index so decoder_out is a pure
   // register output, aligned with out_index.
   netwalk_onehot #(
      .IDX_W (DECODER_IN_WIDTH)
   ) u_onehot (
      .idx    (index_d),
      .onehot (onehot_d)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= DEC_IDLE;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_index_q   <= '0;
         decoder_out_q <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= valid_d;
         out_last_q    <= last_d;
         out_index_q   <= index_d;
         decoder_out_q <= valid_d ? onehot_d : '0;
      end
   end

   // Next-state and next-beat selection. During a sweep out_index doubles
   // as the sweep counter; it never wraps because beat 63 ends the sweep.
   always_comb begin
      state_d   = state_q;
      valid_d   = out_valid_q;
      index_d   = out_index_q;
      last_d    = out_last_q;
      index_inc = out_index_q + 1'b1;
      case (state_q)
         DEC_IDLE: begin
            if (sweep_go) begin
               state_d = DEC_SWEEP;
               valid_d = 1'b1;
               index_d = '0;
               last_d  = 1'b0;
            end else if (req_take) begin
               valid_d = 1'b1;
               index_d = decoder_in;
               last_d  = 1'b0;
            end else if (out_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end
         DEC_SWEEP: begin
            if (beat_take) begin
               if (out_last_q) begin
                  state_d = DEC_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  index_d = index_inc;
                  last_d  = (index_inc == '1);
               end
            end
         end
         default: state_d = DEC_IDLE;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      load_ok     = !out_valid_q || out_ready;
      in_ready    = (state_q == DEC_IDLE) && load_ok && !sweep_start;
      sweep_go    = (state_q == DEC_IDLE) && load_ok && sweep_start;
      req_take    = in_valid && in_ready;
      beat_take   = out_valid_q && out_ready;
      busy        = (state_q == DEC_SWEEP);
      out_valid   = out_valid_q;
      out_last    = out_last_q;
      out_index   = out_index_q;
      decoder_out = decoder_out_q;
   end

endmodule

// File: tb/tb_netwalk_decoder.sv
module tb_netwalk_decoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  decoder_in;
   logic        sweep_start;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] decoder_out;
   logic [5:0]  out_index;
   logic        out_last;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   netwalk_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .decoder_in  (decoder_in),
      .sweep_start (sweep_start),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .decoder_out (decoder_out),
      .out_index   (out_index),
      .out_last    (out_last),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then move 1ns past it to drive/sample.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      in_valid    = 1'b0;
      decoder_in  = '0;
      sweep_start = 1'b0;
      out_ready   = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || decoder_out !== 64'h0 || out_index !== 6'd0 ||
          out_last !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got v=%b d=%h i=%0d l=%b b=%b required v=0 d=0 i=0 l=0 b=0",
                  out_valid, decoder_out, out_index, out_last, busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      // Hold a beat stalled, then reset asynchronously.
      in_valid   = 1'b1;
      decoder_in = 6'd3;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || decoder_out !== 64'h8) begin
         failures++;
         $display("FAIL stall_before_reset: got v=%b d=%h required v=1 d=0000000000000008",
                  out_valid, decoder_out);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || decoder_out !== 64'h0 || busy !== 1'b0 || out_index !== 6'd0) begin
         failures++;
         $display("FAIL async_reset_stall: got v=%b d=%h b=%b i=%0d required v=0 d=0 b=0 i=0",
                  out_valid, decoder_out, busy, out_index);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_single();
      in_valid   = 1'b1;
      decoder_in = 6'd37;
      out_ready  = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || decoder_out !== 64'h0000_0020_0000_0000 ||
          out_index !== 6'd37 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL single_37: got v=%b d=%h i=%0d l=%b required v=1 d=0000002000000000 i=37 l=0",
                  out_valid, decoder_out, out_index, out_last);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || decoder_out !== 64'h0) begin
         failures++;
         $display("FAIL single_drain: got v=%b d=%h required v=0 d=0", out_valid, decoder_out);
      end
   endtask

   task automatic test_stall();
      in_valid   = 1'b1;
      decoder_in = 6'd5;
      out_ready  = 1'b0;
      step();
      decoder_in = 6'd9;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || decoder_out !== 64'h20 || out_index !== 6'd5) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h i=%0d required rdy=0 v=1 d=0000000000000020 i=5",
                     c, in_ready, out_valid, decoder_out, out_index);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_release_ready: got %b required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || decoder_out !== 64'h200 || out_index !== 6'd9) begin
         failures++;
         $display("FAIL stall_next_beat: got v=%b d=%h i=%0d required v=1 d=0000000000000200 i=9",
                  out_valid, decoder_out, out_index);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_drain: got v=%b required 0", out_valid);
      end
   endtask

   task automatic test_sweep();
      logic [63:0] exp_d;
      sweep_start = 1'b1;
      out_ready   = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL sweep_start_ready: got %b required 0", in_ready);
      end
      step();
      sweep_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         exp_d = 64'h1 << k;
         checks++;
         if (out_valid !== 1'b1 || decoder_out !== exp_d || out_index !== 6'(k) ||
             out_last !== (k == 63) || busy !== 1'b1) begin
            failures++;
            $display("FAIL sweep_beat[%0d]: got v=%b d=%h i=%0d l=%b b=%b required v=1 d=%h i=%0d l=%b b=1",
                     k, out_valid, decoder_out, out_index, out_last, busy, exp_d, k, (k == 63));
         end
         step();
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || decoder_out !== 64'h0) begin
         failures++;
         $display("FAIL sweep_end: got b=%b v=%b rdy=%b d=%h required b=0 v=0 rdy=1 d=0",
                  busy, out_valid, in_ready, decoder_out);
      end
   endtask

   task automatic test_sweep_vs_request();
      sweep_start = 1'b1;
      in_valid    = 1'b1;
      decoder_in  = 6'd12;
      out_ready   = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL race_ready: got %b required 0", in_ready);
      end
      step();
      sweep_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (in_ready !== 1'b0 || out_index !== 6'(k) || busy !== 1'b1) begin
            failures++;
            $display("FAIL race_beat[%0d]: got rdy=%b i=%0d b=%b required rdy=0 i=%0d b=1",
                     k, in_ready, out_index, busy, k);
         end
         step();
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL race_after_sweep: got rdy=%b b=%b required rdy=1 b=0", in_ready, busy);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'd12 || decoder_out !== 64'h1000 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL race_held_req: got v=%b i=%0d d=%h l=%b required v=1 i=12 d=0000000000001000 l=0",
                  out_valid, out_index, decoder_out, out_last);
      end
      step();
   endtask

   task automatic test_sweep_stall_reset();
      sweep_start = 1'b1;
      out_ready   = 1'b1;
      step();
      sweep_start = 1'b0;
      for (int k = 0; k < 20; k++) step();
      out_ready = 1'b0;
      step();
      step();
      checks++;
      if (out_index !== 6'd20 || decoder_out !== 64'h0000_0000_0010_0000 || out_last !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL sweep_stall_20: got i=%0d d=%h l=%b b=%b required i=20 d=0000000000100000 l=0 b=1",
                  out_index, decoder_out, out_last, busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || decoder_out !== 64'h0 || out_index !== 6'd0 || busy !== 1'b0 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL sweep_reset: got v=%b d=%h i=%0d b=%b l=%b required all 0",
                  out_valid, decoder_out, out_index, busy, out_last);
      end
      reset       = 1'b1;
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'd0 || decoder_out !== 64'h1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL sweep_restart: got v=%b i=%0d d=%h b=%b required v=1 i=0 d=0000000000000001 b=1",
                  out_valid, out_index, decoder_out, busy);
      end
      for (int k = 0; k < 64; k++) step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL sweep_restart_end: got b=%b v=%b required b=0 v=0", busy, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_sweep();
      test_sweep_vs_request();
      test_sweep_stall_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
